// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants, counter sizing and engine state encoding
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 16;
  localparam int SPI_CNT_W = $clog2(SPI_DATA_WIDTH) + 1;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall strobes taken from registered samples
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  // shift the pin through the synchronizer and keep one older sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/spi_device_engine.sv
// spi_device_engine: mode-0 SPI peripheral with oversampled pins, rx valid/ack and a one-word tx buffer
module spi_device_engine
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_abort,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d, rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  buf_full_q, buf_full_d, rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d, underrun_q, underrun_d, abort_q, abort_d;
  logic                  sclk_rise, sclk_fall, cs_sync, cs_rise, cs_fall, mosi_sync;
  logic                  unused_sclk_sync, unused_mosi_rise, unused_mosi_fall;
  logic                  take, start, sample, shift, done;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk (
    .clk(clk), .rst(rst), .in_i(spi_sclk),
    .sync_o(unused_sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .in_i(spi_cs_n),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .in_i(spi_mosi),
    .sync_o(mosi_sync), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  assign take   = tx_load && !buf_full_q;
  assign start  = (state_q == IDLE && cs_fall) || (state_q == WAIT && sclk_fall && !cs_sync);
  assign sample = state_q == SHIFT && !cs_rise && sclk_rise;
  assign shift  = state_q == SHIFT && !cs_rise && sclk_fall;
  assign done   = state_q == DONE;

  // frame sequencing: a deasserted select always wins over a clock edge seen in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_fall ? SHIFT : IDLE;
      SHIFT:   state_d = cs_rise ? IDLE : (sample && bit_cnt_q == LAST_BIT) ? DONE : SHIFT;
      DONE:    state_d = WAIT;
      WAIT:    state_d = cs_rise ? IDLE : start ? SHIFT : WAIT;
      default: state_d = IDLE;
    endcase
  end

  // datapath: a frame start drains the buffer (zeros when empty), loads are only taken into an empty buffer
  always_comb begin
    tx_shift_d = start ? (buf_full_q ? buf_q : '0) : shift ? tx_shift_q << 1 : tx_shift_q;
    rx_shift_d = sample ? {rx_shift_q[DATA_WIDTH-2:0], mosi_sync} : rx_shift_q;
    bit_cnt_d  = start ? '0 : sample ? bit_cnt_q + 1'b1 : bit_cnt_q;
    buf_d      = take ? tx_data : buf_q;
    buf_full_d = take || (buf_full_q && !start);
    rx_data_d  = done ? rx_shift_q : rx_data_q;
    rx_valid_d = done || (rx_valid_q && !rx_ack);
    overrun_d  = overrun_q || (done && rx_valid_q && !rx_ack);
    underrun_d = start && !buf_full_q;
    abort_d    = state_q == SHIFT && cs_rise && bit_cnt_q != '0;
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign spi_miso    = state_q == IDLE ? IDLE_MISO : tx_shift_q[DATA_WIDTH-1];
  assign tx_ready    = !buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
  assign frame_abort = abort_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_spi_device_engine.sv
// tb_spi_device_engine: host-side SPI driver checked against a transaction-level device model
module tb_spi_device_engine;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic clk = 1'b0, rst = 1'b1, spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic tx_load = 1'b0, rx_ack = 1'b0;
  logic [15:0] tx_data = '0;
  logic spi_miso, tx_ready, rx_valid, overrun, underrun, frame_abort, busy;
  logic [15:0] rx_data;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_rv = 0, t_rdy = 0, und_cnt = 0, ab_cnt = 0;
  int t_rise = 0, t_csf = 0;
  logic rv_p = 1'b0, rdy_p = 1'b0;

  bit m_full, m_rv, m_ovr;
  logic [15:0] m_buf, m_rd;
  int m_und = 0, m_ab = 0;

  always #5 clk = ~clk;

  spi_device_engine dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .overrun(overrun),
    .underrun(underrun), .frame_abort(frame_abort), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !rv_p) t_rv <= cyc;
    if (tx_ready && !rdy_p) t_rdy <= cyc;
    if (underrun) und_cnt <= und_cnt + 1;
    if (frame_abort) ab_cnt <= ab_cnt + 1;
    rv_p  <= rx_valid;
    rdy_p <= tx_ready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_full = 0; m_rv = 0; m_ovr = 0; m_buf = '0; m_rd = '0;
  endtask

  function automatic logic [15:0] m_start();
    logic [15:0] w;
    w = m_full ? m_buf : 16'h0000;
    if (!m_full) m_und++;
    m_full = 0;
    return w;
  endfunction

  task automatic m_load(input logic [15:0] w);
    if (!m_full) begin
      m_full = 1;
      m_buf  = w;
    end
  endtask

  task automatic apply_reset();
    rst = 1; spi_cs_n = 1; spi_sclk = 0; spi_mosi = 0; tx_load = 0; rx_ack = 0;
    wclk(3);
    rst = 0;
    m_reset();
    wclk(3);
  endtask

  task automatic load(input logic [15:0] w);
    tx_data = w; tx_load = 1;
    wclk(1);
    tx_load = 0;
    m_load(w);
    check("tx_ready_after_load", tx_ready, 0);
  endtask

  task automatic ack();
    rx_ack = 1;
    wclk(1);
    rx_ack = 0;
    m_rv = 0;
    check("rx_valid_after_ack", rx_valid, 0);
  endtask

  task automatic glitch();
    void'(m_start());
    spi_cs_n = 0;
    wclk(5);
    spi_cs_n = 1;
    wclk(HALF);
    check("glitch_underruns", und_cnt, m_und);
    check("glitch_aborts", ab_cnt, m_ab);
    check("glitch_rx_valid", rx_valid, m_rv);
    check("glitch_tx_ready", tx_ready, !m_full);
    check("glitch_busy", busy, 0);
  endtask

  // nbits clocks of mo; keep leaves select low for a back-to-back frame; ackd acks in the completion cycle;
  // ml loads mlw into the tx buffer during bit 8
  task automatic run_frame(input logic [15:0] mo, input int nbits, input bit keep, input bit ackd,
                           input bit ml, input logic [15:0] mlw);
    logic [15:0] mi, exp_mi;
    bit fresh, was_full, rv0;
    fresh = spi_cs_n; was_full = m_full; rv0 = m_rv;
    exp_mi = m_start();
    mi = '0;
    if (fresh) begin
      spi_cs_n = 0;
      t_csf = cyc;
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[15-i];
      if (ml && i == 8) begin
        tx_data = mlw; tx_load = 1;
        wclk(1);
        tx_load = 0;
        m_load(mlw);
        wclk(HALF - 1);
      end else wclk(HALF);
      spi_sclk = 1;
      mi = {mi[14:0], spi_miso};
      t_rise = cyc;
      if (i == 15 && ackd) begin
        wclk(SS + 1);
        rx_ack = 1;
        wclk(1);
        rx_ack = 0;
        wclk(HALF - SS - 2);
      end else wclk(HALF);
      spi_sclk = 0;
      if (i == nbits - 1 && !keep) spi_cs_n = 1;
    end
    if (nbits == 16) begin
      if (m_rv && !ackd) m_ovr = 1;
      m_rv = 1;
      m_rd = mo;
    end else if (!keep) m_ab++;
    if (!keep) wclk(HALF);
    check("miso_word", 32'(mi), 32'(exp_mi >> (16 - nbits)));
    check("rx_valid", rx_valid, m_rv);
    check("rx_data", rx_data, m_rd);
    check("overrun", overrun, m_ovr);
    check("underrun_count", und_cnt, m_und);
    check("abort_count", ab_cnt, m_ab);
    if (nbits == 16 && !rv0) check("rx_valid_latency", t_rv - t_rise, SS + 2);
    if (fresh && was_full) check("tx_ready_latency", t_rdy - t_csf, SS + 1);
    if (!keep) begin
      check("tx_ready", tx_ready, !m_full);
      check("busy_after_frame", busy, 0);
    end
  endtask

  initial begin
    m_reset();
    wclk(3);
    check("rst_miso", spi_miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_underrun", underrun, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    wclk(3);

    load(16'hA5C3);
    run_frame(16'h1234, 16, 0, 0, 0, 16'h0);
    ack();
    run_frame(16'hFFFF, 16, 0, 0, 0, 16'h0);
    ack();
    run_frame(16'h0001, 16, 0, 0, 0, 16'h0);
    run_frame(16'h8000, 16, 0, 0, 0, 16'h0);
    apply_reset();
    run_frame(16'h0001, 16, 0, 0, 0, 16'h0);
    run_frame(16'h8000, 16, 0, 1, 0, 16'h0);
    ack();
    run_frame(16'hBEEF, 7, 0, 0, 0, 16'h0);
    run_frame(16'h5555, 16, 0, 0, 0, 16'h0);
    ack();
    load(16'h1111);
    load(16'h2222);
    glitch();
    glitch();
    ack();

    load(16'h1357);
    run_frame(16'hDEAD, 16, 1, 0, 1, 16'h2468);
    run_frame(16'hBEEF, 16, 0, 1, 0, 16'h0);

    run_frame(16'h0F0F, 9, 1, 0, 1, 16'h7777);
    #2;
    check("busy_mid_frame", busy, 1);
    rst = 1;
    #1;
    check("async_rst_miso", spi_miso, 0);
    check("async_rst_tx_ready", tx_ready, 1);
    check("async_rst_rx_data", rx_data, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_abort", frame_abort, 0);
    check("async_rst_busy", busy, 0);
    spi_cs_n = 1; spi_sclk = 0;
    wclk(3);
    rst = 0;
    m_reset();
    wclk(3);
    load(16'hC33C);
    run_frame(16'h00FF, 16, 0, 0, 0, 16'h0);

    for (int k = 0; k < 20; k++) begin
      int nb;
      bit ad;
      if ($urandom_range(1, 0) == 1) load(16'($urandom));
      if ($urandom_range(3, 0) == 0) load(16'($urandom));
      if ($urandom_range(1, 0) == 1) ack();
      if (k % 7 == 3) glitch();
      nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 1)) : 16;
      ad = nb == 16 && $urandom_range(1, 0) == 1;
      run_frame(16'($urandom), nb, 0, ad, 0, 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
